// File: rtl/clkmon_pkg.sv
// Shared types and helpers for the clock monitor.
// Tolerance compare is done on 17 signed bits, so period widths up to 16 bits are supported.
package clkmon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } clkmon_state_e;

  localparam int CLKMON_CMP_W = 17;

  // |cnt - exp_p| <= tol, evaluated with one spare sign bit so no operand wraps
  function automatic logic in_tol(input logic [15:0] cnt,
                                  input logic [15:0] exp_p,
                                  input logic [15:0] tol);
    logic signed [CLKMON_CMP_W-1:0] w_diff;
    logic signed [CLKMON_CMP_W-1:0] w_abs;
    w_diff = $signed({1'b0, cnt}) - $signed({1'b0, exp_p});
    w_abs  = (w_diff < 17'sd0) ? -w_diff : w_diff;
    return (w_abs <= $signed({1'b0, tol}));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, async reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // metastability filter: two back-to-back flops in the clk_i domain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/clock_monitor.sv
// Measures mon_clk_i periods in clk_i cycles, tracks lock and reports errors/timeouts.
// Optional CLKMON_STICKY_ERR_EN: err_o becomes a sticky level cleared by err_clr_i.
module clock_monitor
  import clkmon_pkg::*;
#(
  parameter int PER_W      = 8,
  parameter int EXP_PERIOD = 2,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             mon_clk_i,
`ifdef CLKMON_STICKY_ERR_EN
  input  logic             err_clr_i,
`endif
  output logic [PER_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             locked_o,
  output logic             err_o,
  output logic             timeout_o
);

  localparam int               GOOD_W    = $clog2(LOCK_CNT + 1);
  localparam logic [PER_W-1:0] CNT_MAX   = {PER_W{1'b1}};
  localparam logic [PER_W-1:0] TIMEOUT_V = PER_W'(TIMEOUT);
  localparam logic [GOOD_W-1:0] LOCK_V   = GOOD_W'(LOCK_CNT);

  clkmon_state_e     r_state;
  logic [PER_W-1:0]  r_cnt;
  logic [GOOD_W-1:0] r_good;
  logic [PER_W-1:0]  r_period;
  logic              r_period_valid;
  logic              r_locked;
  logic              r_err;
  logic              r_timeout;
  logic              r_mon_dly;

  logic              w_mon_sync;
  logic              w_rise;
  logic              w_good;
  logic [PER_W-1:0]  w_cnt_inc;

  sync_2ff u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_d   (mon_clk_i),
    .o_q   (w_mon_sync)
  );

  assign w_rise    = w_mon_sync & ~r_mon_dly;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + PER_W'(1);
  // a saturated counter sits far above EXP_PERIOD+TOL, so it can never read as good
  assign w_good    = in_tol(16'(r_cnt), 16'(EXP_PERIOD), 16'(TOL));

  // edge-detect delay flop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mon_dly <= 1'b0;
    end else begin
      r_mon_dly <= w_mon_sync;
    end
  end

  // monitor FSM with period counter, lock counter and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_good         <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_err          <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_period_valid <= 1'b0;
      r_timeout      <= 1'b0;
`ifdef CLKMON_STICKY_ERR_EN
      if (err_clr_i) begin
        r_err <= 1'b0;
      end
`else
      r_err <= 1'b0;
`endif
      if (!enable_i) begin
        r_state  <= IDLE;
        r_locked <= 1'b0;
        r_cnt    <= '0;
        r_good   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= ACQ;
            r_cnt   <= '0;
          end
          ACQ, TRACK, LOCKED: begin
            if (w_rise) begin
              r_cnt <= PER_W'(1);
              if (r_state == ACQ) begin
                // first edge only aligns us; the partial period before it is discarded
                r_state <= TRACK;
              end else begin
                r_period       <= r_cnt;
                r_period_valid <= 1'b1;
                if (w_good) begin
                  if (r_state == TRACK) begin
                    r_good <= r_good + GOOD_W'(1);
                    if (r_good + GOOD_W'(1) == LOCK_V) begin
                      r_state  <= LOCKED;
                      r_locked <= 1'b1;
                    end
                  end
                end else begin
                  r_state  <= TRACK;
                  r_locked <= 1'b0;
                  r_good   <= '0;
                  r_err    <= 1'b1;
                end
              end
            end else if (r_cnt == TIMEOUT_V) begin
              r_state   <= ACQ;
              r_timeout <= 1'b1;
              r_locked  <= 1'b0;
              r_good    <= '0;
              r_cnt     <= '0;
`ifdef CLKMON_STICKY_ERR_EN
              r_err     <= 1'b1;
`endif
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign period_o       = r_period;
  assign period_valid_o = r_period_valid;
  assign locked_o       = r_locked;
  assign err_o          = r_err;
  assign timeout_o      = r_timeout;

endmodule

// File: tb/tb_clock_monitor.sv
// Self-checking bench: drives random mon_clk_i periods into two monitors (TOL=0 and TOL=1)
// and compares their output event logs against an event-level model built from the rise times.
module tb_clock_monitor;

  localparam int EXP_P   = 2;
  localparam int LOCK_N  = 4;
  localparam int TMO     = 32;
  localparam int K_VALID = 0;
  localparam int K_ERR   = 1;
  localparam int K_TO    = 2;
  localparam int K_LOCK  = 3;
  localparam int K_UNLK  = 4;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       enable_i;
  logic       mon_clk_i;
  logic [7:0] period0, period1;
  logic       pv0, pv1, lk0, lk1, err0, err1, to0, to1;
`ifdef CLKMON_STICKY_ERR_EN
  logic       err_clr;
`endif

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  bit  log_en   = 1'b0;
  logic lk0_d = 1'b0, lk1_d = 1'b0;
  int  ref0;
  int  end_cyc;
  bit  final_lk[2];
  ev_t log0_q[$];
  ev_t log1_q[$];
  int  rise_q[$];

  always #5 clk_i = ~clk_i;

  clock_monitor u_dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .mon_clk_i      (mon_clk_i),
`ifdef CLKMON_STICKY_ERR_EN
    .err_clr_i      (err_clr),
`endif
    .period_o       (period0),
    .period_valid_o (pv0),
    .locked_o       (lk0),
    .err_o          (err0),
    .timeout_o      (to0)
  );

  clock_monitor #(.TOL(1)) u_dut_t1 (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .mon_clk_i      (mon_clk_i),
`ifdef CLKMON_STICKY_ERR_EN
    .err_clr_i      (err_clr),
`endif
    .period_o       (period1),
    .period_valid_o (pv1),
    .locked_o       (lk1),
    .err_o          (err1),
    .timeout_o      (to1)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic ev_t mk(input int c, input int k, input int v);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    return e;
  endfunction

  task automatic rec(input int d, input logic pv, input logic [7:0] p, input logic e,
                     input logic t, input logic lk, input logic lkd);
    ev_t q[$];
    if (pv) q.push_back(mk(cyc, K_VALID, int'(p)));
`ifndef CLKMON_STICKY_ERR_EN
    if (e) q.push_back(mk(cyc, K_ERR, 0));
`endif
    if (t) q.push_back(mk(cyc, K_TO, 0));
    if (lk && !lkd) q.push_back(mk(cyc, K_LOCK, 0));
    if (!lk && lkd) q.push_back(mk(cyc, K_UNLK, 0));
    foreach (q[i]) begin
      if (d == 0) log0_q.push_back(q[i]);
      else        log1_q.push_back(q[i]);
    end
  endtask

  // output event logger, sampled 1 time unit after each rising edge
  always @(posedge clk_i) begin
    cyc++;
    #1;
    if (log_en) begin
      rec(0, pv0, period0, err0, to0, lk0, lk0_d);
      rec(1, pv1, period1, err1, to1, lk1, lk1_d);
    end
    lk0_d = lk0;
    lk1_d = lk1;
  end

  // one mon_clk_i period: high for hi cycles, low for lo; DUT acts on the rise 3 edges later
  task automatic drive_period(input int hi, input int lo);
    @(negedge clk_i);
    mon_clk_i = 1'b1;
    rise_q.push_back(cyc + 3);
    repeat (hi - 1) @(negedge clk_i);
    @(negedge clk_i);
    mon_clk_i = 1'b0;
    repeat (lo - 1) @(negedge clk_i);
  endtask

  // Event model: walk the rise times; periods are gaps between rises, a gap longer than
  // TMO cycles since the last reference point yields a timeout and re-acquisition.
  task automatic check_phase(input int tol, input int d);
    ev_t exp_q[$];
    ev_t got_q[$];
    int  r, good, p, lim, n;
    bit  acq, locked;
    r = ref0; acq = 1'b1; good = 0; locked = 1'b0;
    n = rise_q.size();
    for (int i = 0; i <= n; i++) begin
      lim = (i < n) ? rise_q[i] : end_cyc + 1;
      while (lim > r + TMO) begin
        exp_q.push_back(mk(r + TMO, K_TO, 0));
        if (locked) exp_q.push_back(mk(r + TMO, K_UNLK, 0));
        locked = 1'b0; good = 0; acq = 1'b1;
        r = r + TMO + 1;
      end
      if (i < n) begin
        if (acq) begin
          acq = 1'b0;
        end else begin
          p = rise_q[i] - r;
          exp_q.push_back(mk(rise_q[i], K_VALID, p));
          if ((p - EXP_P <= tol) && (EXP_P - p <= tol)) begin
            if (!locked) begin
              good++;
              if (good == LOCK_N) begin
                locked = 1'b1;
                exp_q.push_back(mk(rise_q[i], K_LOCK, 0));
              end
            end
          end else begin
`ifndef CLKMON_STICKY_ERR_EN
            exp_q.push_back(mk(rise_q[i], K_ERR, 0));
`endif
            good = 0;
            if (locked) begin
              locked = 1'b0;
              exp_q.push_back(mk(rise_q[i], K_UNLK, 0));
            end
          end
        end
        r = rise_q[i];
      end
    end
    final_lk[d] = locked;
    if (d == 0) got_q = log0_q;
    else        got_q = log1_q;
    check_val($sformatf("d%0d_ev_count", d), got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check_val($sformatf("d%0d_ev%0d_cyc", d, i), got_q[i].cyc, exp_q[i].cyc);
      check_val($sformatf("d%0d_ev%0d_kind", d, i), got_q[i].kind, exp_q[i].kind);
      check_val($sformatf("d%0d_ev%0d_val", d, i), got_q[i].val, exp_q[i].val);
    end
  endtask

  task automatic start_phase();
    log0_q.delete();
    log1_q.delete();
    rise_q.delete();
    @(negedge clk_i);
    enable_i = 1'b1;
    log_en   = 1'b1;
    ref0     = cyc + 2;
  endtask

  task automatic end_phase();
    repeat (4) @(negedge clk_i);
    log_en  = 1'b0;
    end_cyc = cyc;
    check_phase(0, 0);
    check_phase(1, 1);
    check_val("d0_final_locked", int'(lk0), int'(final_lk[0]));
    check_val("d1_final_locked", int'(lk1), int'(final_lk[1]));
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_period"}, int'(period0), 0);
    check_val({tag, "_valid"}, int'(pv0), 0);
    check_val({tag, "_locked"}, int'(lk0), 0);
    check_val({tag, "_err"}, int'(err0), 0);
    check_val({tag, "_timeout"}, int'(to0), 0);
    check_val({tag, "_locked_t1"}, int'(lk1), 0);
  endtask

  initial begin
    int hi, lo, quiet;
    rst_i = 1'b1; enable_i = 1'b0; mon_clk_i = 1'b0;
`ifdef CLKMON_STICKY_ERR_EN
    err_clr = 1'b0;
`endif
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // lock, timeout, relock, stretched period, 2/3 alternation, timeout boundary
    start_phase();
    repeat (6) drive_period(1, 1);
    repeat (40) @(negedge clk_i);
    repeat (6) drive_period(1, 1);
    drive_period(2, 2);
    repeat (5) drive_period(1, 1);
    for (int i = 0; i < 4; i++) begin
      drive_period(1, 1);
      drive_period(2, 1);
    end
    drive_period(2, 2);
    repeat (5) drive_period(1, 1);
    drive_period(1, 31);
    repeat (5) drive_period(1, 1);
    drive_period(1, 32);
    repeat (6) drive_period(1, 1);
    end_phase();
    check_val("pre_rst_locked", int'(lk0), 1);

    // asynchronous reset in the middle of a cycle while locked
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1 check_all_zero("async_rst");
    enable_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // randomized periods, including gaps around the timeout limit
    start_phase();
    for (int i = 0; i < 60; i++) begin
      hi = $urandom_range(1, 3);
      lo = ($urandom_range(0, 9) == 0) ? $urandom_range(28, 40) : $urandom_range(1, 3);
      drive_period(hi, lo);
    end
    repeat (6) drive_period(1, 1);
    end_phase();

    // enable low forces idle: lock drops, rises are ignored, no timeouts
    @(negedge clk_i);
    enable_i = 1'b0;
    @(negedge clk_i);
    check_val("dis_locked", int'(lk0), 0);
    check_val("dis_locked_t1", int'(lk1), 0);
    quiet = 0;
    for (int i = 0; i < 50; i++) begin
      mon_clk_i = (i < 40) ? ~mon_clk_i : 1'b0;
      @(negedge clk_i);
      if (pv0 || to0 || lk0 || err0) quiet++;
    end
    check_val("dis_quiet", quiet, 0);

    // re-enable from idle, then let it time out twice
    start_phase();
    repeat (8) drive_period(1, 1);
    repeat (70) @(negedge clk_i);
    end_phase();

`ifdef CLKMON_STICKY_ERR_EN
    repeat (6) drive_period(1, 1);
    @(negedge clk_i) err_clr = 1'b1;
    @(negedge clk_i) err_clr = 1'b0;
    check_val("sticky_clr0", int'(err0), 0);
    drive_period(2, 2);
    drive_period(1, 1);
    repeat (3) @(negedge clk_i);
    check_val("sticky_bad", int'(err0), 1);
    repeat (4) @(negedge clk_i);
    check_val("sticky_hold", int'(err0), 1);
    @(negedge clk_i) err_clr = 1'b1;
    @(negedge clk_i) err_clr = 1'b0;
    check_val("sticky_clr1", int'(err0), 0);
    repeat (40) @(negedge clk_i);
    check_val("sticky_timeout", int'(err0), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
